// File: rtl/block_feeder.sv
// ============================================================================
// block_feeder -- streams fixed-length sample blocks from an image buffer to a
//                 processing element, one block per controller DATA phase.
// Optional: define BLOCK_FEEDER_ERR_EN to add the sticky protocol error output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module block_feeder #(
    parameter int DATA_W     = 8,
    parameter int BLOCK_LEN  = 9,
    parameter int NUM_BLOCKS = 16,
    parameter int ADDR_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              data,
    input  logic              result,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pe_valid,
    output logic [DATA_W-1:0] pe_data,
    input  logic              pe_ready,
    output logic              dataSent,
    output logic              blockDone,
    output logic              imageDone,
    output logic [ADDR_W-1:0] block_idx
`ifdef BLOCK_FEEDER_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int                CNT_W     = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BLOCK_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_BLK  = ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [ADDR_W-1:0] BLK_LEN_A = ADDR_W'(BLOCK_LEN);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FETCH       = 2'd1,
        STREAM      = 2'd2,
        WAIT_RESULT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  fetch_cnt;
    logic [ADDR_W-1:0] fetch_addr;
    logic              handshake;

    logic start_fetch;
    logic next_fetch;
    logic capture;
    logic xfer_last;
    logic abort;
    logic finish_block;
    logic finish_image;

    assign handshake  = pe_valid && pe_ready;
    assign fetch_cnt  = start_fetch ? '0 : sample_cnt + CNT_W'(1);
    assign fetch_addr = (block_idx * BLK_LEN_A) + ADDR_W'(fetch_cnt);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        start_fetch  = 1'b0;
        next_fetch   = 1'b0;
        capture      = 1'b0;
        xfer_last    = 1'b0;
        abort        = 1'b0;
        finish_block = 1'b0;
        finish_image = 1'b0;
        case (state)
            IDLE: begin
                if (data) begin
                    state_nxt   = FETCH;
                    start_fetch = 1'b1;
                end
            end
            FETCH: begin
                if (!data) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else begin
                    state_nxt = STREAM;
                    capture   = 1'b1;
                end
            end
            STREAM: begin
                // Dropping data wins over a same-cycle handshake.
                if (!data) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (handshake) begin
                    if (sample_cnt == LAST_CNT) begin
                        state_nxt = WAIT_RESULT;
                        xfer_last = 1'b1;
                    end else begin
                        state_nxt  = FETCH;
                        next_fetch = 1'b1;
                    end
                end
            end
            WAIT_RESULT: begin
                // Waiting out the dataSent cycle keeps the done pulses apart.
                if (result && !dataSent) begin
                    state_nxt = IDLE;
                    if (block_idx == LAST_BLK) begin
                        finish_image = 1'b1;
                    end else begin
                        finish_block = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample_cnt <= '0;
            block_idx  <= '0;
            mem_addr   <= '0;
            pe_data    <= '0;
            pe_valid   <= 1'b0;
            dataSent   <= 1'b0;
            blockDone  <= 1'b0;
            imageDone  <= 1'b0;
        end else begin
            dataSent  <= xfer_last;
            blockDone <= finish_block;
            imageDone <= finish_image;

            if (start_fetch || next_fetch) begin
                mem_addr   <= fetch_addr;
                sample_cnt <= fetch_cnt;
            end
            if (xfer_last || abort) begin
                sample_cnt <= '0;
            end

            if (capture) begin
                pe_data  <= mem_rdata;
                pe_valid <= 1'b1;
            end
            if (next_fetch || xfer_last || abort) begin
                pe_valid <= 1'b0;
            end

            if (finish_block) begin
                block_idx <= block_idx + ADDR_W'(1);
            end else if (finish_image) begin
                block_idx <= '0;
            end
        end
    end

`ifdef BLOCK_FEEDER_ERR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if ((result && (state == FETCH || state == STREAM)) ||
                     (pe_ready && !pe_valid)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_block_feeder.sv
// Self-checking bench for block_feeder: a controller/PE model drives blocks with
// random backpressure and compares every sample against the buffer contents.
`default_nettype none

module tb_block_feeder;

    localparam int DATA_W     = 8;
    localparam int BLOCK_LEN  = 9;
    localparam int NUM_BLOCKS = 16;
    localparam int ADDR_W     = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              data = 1'b0;
    logic              result = 1'b0;
    logic              pe_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] block_idx;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pe_data;
    logic              pe_valid;
    logic              dataSent;
    logic              blockDone;
    logic              imageDone;
`ifdef BLOCK_FEEDER_ERR_EN
    logic              err;
`endif

    logic [DATA_W-1:0] buffer [256];

    int n_checks  = 0;
    int n_pass    = 0;
    int ds_cnt    = 0;
    int bd_cnt    = 0;
    int id_cnt    = 0;
    int excl_viol = 0;
    logic prev_pulse = 1'b0;

    always #5 clock = ~clock;

    assign mem_rdata = buffer[mem_addr];

    block_feeder #(
        .DATA_W    (DATA_W),
        .BLOCK_LEN (BLOCK_LEN),
        .NUM_BLOCKS(NUM_BLOCKS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .data     (data),
        .result   (result),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .pe_valid (pe_valid),
        .pe_data  (pe_data),
        .pe_ready (pe_ready),
        .dataSent (dataSent),
        .blockDone(blockDone),
        .imageDone(imageDone),
        .block_idx(block_idx)
`ifdef BLOCK_FEEDER_ERR_EN
        ,
        .err      (err)
`endif
    );

    // Pulse accounting: counts and exclusivity/back-to-back violations.
    always @(negedge clock) begin
        if (dataSent)  ds_cnt++;
        if (blockDone) bd_cnt++;
        if (imageDone) id_cnt++;
        if ((int'(dataSent) + int'(blockDone) + int'(imageDone)) > 1) excl_viol++;
        if (prev_pulse && (dataSent || blockDone || imageDone)) excl_viol++;
        prev_pulse = dataSent || blockDone || imageDone;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Controller + PE model for one DATA phase. abort_k >= 0 drops data while
    // offering a handshake on sample abort_k, which must then be discarded.
    task automatic stream_block(input int blk, input int ready_pct,
                                input int stall_k, input int abort_k);
        int  k;
        int  cyc;
        int  stall;
        int  base;
        bit  prev_xfer;
        bit  prev_stall;
        bit  done;
        k = 0; cyc = 0; stall = 0; prev_xfer = 0; prev_stall = 0; done = 0;
        base = blk * BLOCK_LEN;
        data = 1'b1;
        pe_ready = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (prev_xfer)  check("throughput_gap", pe_valid, 0);
            if (prev_stall) check("hold_valid", pe_valid, 1);
            prev_xfer = 0;
            prev_stall = 0;
            pe_ready = 1'b0;
            if (dataSent) begin
                check("samples_per_block", k, BLOCK_LEN);
                done = 1;
                data = 1'b0;
            end else if (pe_valid) begin
                check("mem_addr", mem_addr, base + k);
                check("pe_data", pe_data, buffer[base + k]);
                if (k == abort_k) begin
                    data = 1'b0;
                    pe_ready = 1'b1;
                    done = 1;
                end else if (k == stall_k && stall < 3) begin
                    stall++;
                    prev_stall = 1;
                end else if ($urandom_range(99) < ready_pct) begin
                    pe_ready = 1'b1;
                    prev_xfer = 1;
                    k++;
                end else begin
                    prev_stall = 1;
                end
            end
        end
        check("stream_done", done, 1);
        if (abort_k >= 0) begin
            pe_ready = 1'b0;
            repeat (3) begin
                @(negedge clock);
                check("abort_valid", pe_valid, 0);
                check("abort_no_sent", dataSent, 0);
            end
            check("abort_keeps_block", block_idx, blk);
        end
    endtask

    task automatic finish_block(input int blk);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 0;
        result = 1'b1;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (blockDone || imageDone) seen = 1;
        end
        result = 1'b0;
        check("done_seen", seen, 1);
        check("blockDone", blockDone, (blk != NUM_BLOCKS - 1));
        check("imageDone", imageDone, (blk == NUM_BLOCKS - 1));
        check("block_idx_next", block_idx, (blk + 1) % NUM_BLOCKS);
        @(negedge clock);
        check("pulse_width", blockDone || imageDone, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) buffer[i] = DATA_W'(i);

        // Reset state
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("rst_pe_valid", pe_valid, 0);
        check("rst_pe_data", pe_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_block_idx", block_idx, 0);
        check("rst_dataSent", dataSent, 0);
        check("rst_blockDone", blockDone, 0);
        check("rst_imageDone", imageDone, 0);
        reset = 1'b1;
        @(negedge clock);

        // result outside WAIT_RESULT must be ignored
        result = 1'b1;
        repeat (3) @(negedge clock);
        result = 1'b0;
        @(negedge clock);
        check("idle_result_block_idx", block_idx, 0);
        check("idle_result_no_done", bd_cnt + id_cnt, 0);

        // Block 0: full throughput, buffer[i] = i
        stream_block(0, 100, -1, -1);
        finish_block(0);
        // Block 1: 3-cycle stall on sample 4
        stream_block(1, 100, 4, -1);
        finish_block(1);
        // Block 2: abort on sample 6, then restart from address 18
        stream_block(2, 100, -1, 6);
        stream_block(2, 60, -1, -1);
        finish_block(2);
        // Block 3: abort coincident with the final transfer
        stream_block(3, 100, -1, BLOCK_LEN - 1);
        stream_block(3, 70, -1, -1);
        finish_block(3);

        // Remaining blocks with random data and random backpressure
        for (int i = 0; i < 256; i++) buffer[i] = DATA_W'($urandom);
        for (int b = 4; b < NUM_BLOCKS; b++) begin
            stream_block(b, 50, -1, -1);
            finish_block(b);
        end
        check("image_blockDone_count", bd_cnt, NUM_BLOCKS - 1);
        check("image_imageDone_count", id_cnt, 1);
        check("image_dataSent_count", ds_cnt, NUM_BLOCKS);
        check("image_wrap_idx", block_idx, 0);
        check("pulse_exclusive", excl_viol, 0);

        // Reset in the middle of block 1 restarts at block 0, sample 0
        stream_block(0, 100, -1, -1);
        finish_block(0);
        data = 1'b1;
        pe_ready = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_block_idx", block_idx, 0);
        check("midrst_pe_valid", pe_valid, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_pe_data", pe_data, 0);
        data = 1'b0;
        pe_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        stream_block(0, 80, -1, -1);
        finish_block(0);

`ifdef BLOCK_FEEDER_ERR_EN
        reset = 1'b0;
        @(negedge clock);
        check("err_reset", err, 0);
        reset = 1'b1;
        @(negedge clock);
        data = 1'b1;
        pe_ready = 1'b0;
        repeat (3) @(negedge clock);
        result = 1'b1;
        @(negedge clock);
        result = 1'b0;
        check("err_set", err, 1);
        data = 1'b0;
        repeat (4) @(negedge clock);
        check("err_sticky", err, 1);
        reset = 1'b0;
        #1;
        check("err_clear", err, 0);
        @(negedge clock);
        reset = 1'b1;
`endif

        @(negedge clock);
        check("pulse_exclusive_final", excl_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/block_feeder.md
BLOCK_FEEDER -- requirements
Module: block_feeder

Interface
- REQ-001 Parameter DATA_W, default 8: sample width in bits.
- REQ-002 Parameter BLOCK_LEN, default 9: samples per block.
- REQ-003 Parameter NUM_BLOCKS, default 16: blocks per image.
- REQ-004 Parameter ADDR_W, default 8: buffer address width; NUM_BLOCKS*BLOCK_LEN SHALL be <= 2^ADDR_W.
- REQ-005 Port clock, input, 1: single clock; all state updates on its rising edge.
- REQ-006 Port reset, input, 1: asynchronous, active-low reset.
- REQ-007 Port data, input, 1: controller request to stream the current block, held high for the whole DATA phase.
- REQ-008 Port result, input, 1: controller is in the RESULT phase.
- REQ-009 Port mem_addr, output, ADDR_W: read address to the image buffer.
- REQ-010 Port mem_rdata, input, DATA_W: buffer read data, valid exactly 1 cycle after mem_addr is presented.
- REQ-011 Port pe_valid, output, 1: pe_data holds a valid sample.
- REQ-012 Port pe_data, output, DATA_W: sample to the processing element.
- REQ-013 Port pe_ready, input, 1: processing element accepts the sample this cycle.
- REQ-014 Port dataSent, output, 1: one-cycle pulse when the last sample of the block is accepted.
- REQ-015 Port blockDone, output, 1: one-cycle pulse when a non-final block completes.
- REQ-016 Port imageDone, output, 1: one-cycle pulse when the final block completes.
- REQ-017 Port block_idx, output, ADDR_W: index of the current block.

Function
- REQ-018 States: IDLE, FETCH, STREAM, WAIT_RESULT.
- REQ-019 IDLE: when data=1, move to FETCH; otherwise stay in IDLE.
- REQ-020 FETCH: drive mem_addr = block_idx*BLOCK_LEN + sample_cnt for 1 cycle, then move to STREAM.
- REQ-021 STREAM entry: register mem_rdata into pe_data and assert pe_valid.
- REQ-022 STREAM hold: pe_valid and pe_data stay stable until pe_valid&&pe_ready.
- REQ-023 Throughput: at most 1 sample per 2 cycles.
- REQ-024 STREAM transfer (pe_valid&&pe_ready) with sample_cnt < BLOCK_LEN-1: increment sample_cnt, deassert pe_valid, move to FETCH.
- REQ-025 STREAM transfer with sample_cnt == BLOCK_LEN-1: pulse dataSent on the next cycle, clear sample_cnt, move to WAIT_RESULT.
- REQ-026 WAIT_RESULT with result=1 and block_idx < NUM_BLOCKS-1: pulse blockDone for 1 cycle, increment block_idx, move to IDLE.
- REQ-027 WAIT_RESULT with result=1 and block_idx == NUM_BLOCKS-1: pulse imageDone for 1 cycle, wrap block_idx to 0, move to IDLE; blockDone stays low.
- REQ-028 Abort: data=0 while in FETCH or STREAM moves to IDLE on the next edge, clears pe_valid and sample_cnt, and keeps block_idx; the next data=1 restarts the block at sample 0.
- REQ-029 Abort takes priority over a transfer in the same cycle; that transfer is discarded and dataSent is not pulsed.
- REQ-030 result=1 outside WAIT_RESULT is ignored.
- REQ-031 dataSent, blockDone and imageDone are mutually exclusive and never high for 2 consecutive cycles.

Reset
- REQ-032 While reset=0 (asynchronous): state=IDLE, sample_cnt=0, block_idx=0, mem_addr=0, pe_data=0, and pe_valid, dataSent, blockDone, imageDone all 0.
- REQ-033 Reset asserted mid-operation abandons the image; after release the feeder restarts at block 0, sample 0.

Configuration
- REQ-034 Macro BLOCK_FEEDER_ERR_EN defined: add output err (1 bit), set sticky when result=1 in FETCH or STREAM, or when pe_ready=1 while pe_valid=0; err is cleared only by reset.
- REQ-035 Macro BLOCK_FEEDER_ERR_EN undefined: no err port and no err logic.

Verification
- REQ-036 Reset: hold reset=0 for 5 cycles -> all outputs 0 and block_idx=0.
- REQ-037 Single block, BLOCK_LEN=9, pe_ready=1, buffer[i]=i: data=1 -> pe_data sequence 0..8 on addresses 0..8, one dataSent pulse, then result=1 -> blockDone pulse and block_idx=1.
- REQ-038 Backpressure: pe_ready=0 for 3 cycles on sample 4 -> pe_valid and pe_data=4 held stable, no skipped or duplicated samples.
- REQ-039 Image wrap, NUM_BLOCKS=16: run 16 blocks -> exactly 15 blockDone pulses and 1 imageDone pulse, block_idx back to 0, block 15 reads addresses 135..143.
- REQ-040 Abort: drop data after sample 5 of block 2 -> IDLE, pe_valid=0, no dataSent; re-raise data -> restart at address 18.
- REQ-041 With BLOCK_FEEDER_ERR_EN defined: assert result during STREAM -> err=1 and stays 1 until reset=0.
